// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding, pattern lengths and the LED pattern lookup for the LED sequencer.
package led_ctrl_pkg;

  localparam int LED_W = 8;
  localparam int POS_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [POS_W-1:0] LAST_OFF    = POS_W'(0);
  localparam logic [POS_W-1:0] LAST_WALK   = POS_W'(7);
  localparam logic [POS_W-1:0] LAST_BOUNCE = POS_W'(13);
  localparam logic [POS_W-1:0] LAST_BLINK  = POS_W'(1);

  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  function automatic logic [POS_W-1:0] last_pos(input mode_e m);
    case (m)
      MODE_WALK:   last_pos = LAST_WALK;
      MODE_BOUNCE: last_pos = LAST_BOUNCE;
      MODE_BLINK:  last_pos = LAST_BLINK;
      default:     last_pos = LAST_OFF;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] pattern(input mode_e m, input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] mirror;
    mirror = POS_W'(14) - pos;
    case (m)
      MODE_WALK:   pattern = LED_ONE << pos[2:0];
      // The return leg retraces the outward leg without repeating either end LED.
      MODE_BOUNCE: pattern = (pos < POS_W'(8)) ? (LED_ONE << pos[2:0]) : (LED_ONE << mirror[2:0]);
      MODE_BLINK:  pattern = pos[0] ? '0 : '1;
      default:     pattern = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts 0..STEP_DIV-1 and raises o_tick during the terminal count.
module led_prescaler #(
  parameter int STEP_DIV = 1000000,
  parameter int DIV_W    = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] cnt_p1;

  assign o_tick = (cnt_p1 == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset)     cnt_p1 <= '0;
    else if (o_tick) cnt_p1 <= '0;
    else             cnt_p1 <= cnt_p1 + DIV_W'(1);
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: applies handshaked mode requests only at pattern boundaries.
// Optional LED_CTRL_PWM_EN adds an i_duty brightness control on o_led.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 1000000,
  parameter int DIV_W    = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
`ifdef LED_CTRL_PWM_EN
  input  logic [3:0]       i_duty,
`endif
  input  logic             i_mode_valid,
  input  logic [1:0]       i_mode,
  output logic             o_mode_ready,
  output logic [1:0]       o_mode,
  output logic [LED_W-1:0] o_led,
  output logic             o_step,
  output logic             o_busy
);

  logic             tick;
  mode_e            mode_p1, mode_d;
  logic [POS_W-1:0] pos_p1, pos_d;
  logic [LED_W-1:0] pat_p1, pat_d;
  logic             step_p1;
  logic             vld_p1, vld_d;
  mode_e            pend_mode_p1, pend_mode_d;

  led_prescaler #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  always_comb begin
    mode_d      = mode_p1;
    pos_d       = pos_p1;
    pat_d       = pat_p1;
    vld_d       = vld_p1;
    pend_mode_d = pend_mode_p1;
    if (tick) begin
      if (vld_p1 && (pos_p1 == last_pos(mode_p1))) begin
        mode_d = pend_mode_p1;
        pos_d  = '0;
        pat_d  = pattern(pend_mode_p1, '0);
        vld_d  = 1'b0;
      end else begin
        pos_d = (pos_p1 == last_pos(mode_p1)) ? '0 : pos_p1 + POS_W'(1);
        pat_d = pattern(mode_p1, pos_d);
      end
    end
    // Accept and apply are exclusive: accept needs an empty slot, apply needs a full one.
    if (!vld_p1 && i_mode_valid) begin
      vld_d       = 1'b1;
      pend_mode_d = mode_e'(i_mode);
    end
  end

  // Stage p1: mode, position, pattern and pending-request registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_p1 <= MODE_OFF;
      pos_p1  <= '0;
      pat_p1  <= '0;
      step_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      mode_p1 <= mode_d;
      pos_p1  <= pos_d;
      pat_p1  <= pat_d;
      step_p1 <= tick;
      vld_p1  <= vld_d;
    end
  end

  always_ff @(posedge i_clk) begin
    pend_mode_p1 <= pend_mode_d;
  end

  assign o_mode_ready = ~vld_p1;
  assign o_busy       = vld_p1;
  assign o_mode       = mode_p1;
  assign o_step       = step_p1;

`ifdef LED_CTRL_PWM_EN
  logic [3:0] pwm_cnt_p1;

  always_ff @(posedge i_clk) begin
    if (i_reset) pwm_cnt_p1 <= '0;
    else         pwm_cnt_p1 <= pwm_cnt_p1 + 4'd1;
  end

  assign o_led = pat_p1 & {LED_W{pwm_cnt_p1 < i_duty}};
`else
  assign o_led = pat_p1;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed, table-driven bench for led_pattern_ctrl (LED_CTRL_PWM_EN selects the duty tests).
module tb_led_pattern_ctrl;

`ifdef LED_CTRL_PWM_EN
  localparam int SD = 32;
`else
  localparam int SD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] mode;
  logic       o_mode_ready;
  logic [1:0] o_mode;
  logic [7:0] o_led;
  logic       o_step;
  logic       o_busy;
`ifdef LED_CTRL_PWM_EN
  logic [3:0] duty;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .STEP_DIV (SD),
    .DIV_W    (6)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
`ifdef LED_CTRL_PWM_EN
    .i_duty       (duty),
`endif
    .i_mode_valid (valid),
    .i_mode       (mode),
    .o_mode_ready (o_mode_ready),
    .o_mode       (o_mode),
    .o_led        (o_led),
    .o_step       (o_step),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic       v;
    logic [1:0] m;
    logic [7:0] led;
    logic [1:0] om;
    logic       rdy;
    logic       stp;
  } vec_t;

  vec_t vecs[20];

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_step(input string nm);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!o_step && k < 2 * SD);
    n_chk++;
    if (!o_step) begin
      n_fail++;
      $display("FAIL %s: no step pulse within %0d cycles", nm, k);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      valid = vecs[i].v;
      mode  = vecs[i].m;
      cycle();
      check($sformatf("vec%0d led", i),   o_led,                vecs[i].led);
      check($sformatf("vec%0d mode", i),  {6'd0, o_mode},       {6'd0, vecs[i].om});
      check($sformatf("vec%0d ready", i), {7'd0, o_mode_ready}, {7'd0, vecs[i].rdy});
      check($sformatf("vec%0d step", i),  {7'd0, o_step},       {7'd0, vecs[i].stp});
      check($sformatf("vec%0d busy", i),  {7'd0, o_busy},       {7'd0, ~vecs[i].rdy});
    end
    valid = 1'b0;
  endtask

`ifndef LED_CTRL_PWM_EN
  task automatic run_main();
    logic [7:0] walk_seq[4]    = '{8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] bounce_seq[14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    // From reset: WALK requested on the second cycle, first tick four cycles in.
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 8'h01, 2'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 8'h01, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 8'h01, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 8'h01, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 8'h02, 2'd1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, 8'h02, 2'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 8'h02, 2'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 8'h02, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 8'h04, 2'd1, 1'b1, 1'b1};
    // After a reset that discards a pending BLINK: WALK accepted on a tick edge waits one step.
    vecs[12] = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 2'd1, 8'h00, 2'd0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 2'd0, 8'h01, 2'd1, 1'b1, 1'b1};

    rst = 1'b1;
    repeat (3) cycle();
    check("reset led",   o_led,                8'h00);
    check("reset mode",  {6'd0, o_mode},       8'd0);
    check("reset ready", {7'd0, o_mode_ready}, 8'd1);
    check("reset busy",  {7'd0, o_busy},       8'd0);
    check("reset step",  {7'd0, o_step},       8'd0);
    rst = 1'b0;
    run_vecs(0, 11);

    wait_step("walk to 08");
    check("walk 08", o_led, 8'h08);

    // BLINK requested at 08; a BOUNCE held on valid meanwhile must be ignored.
    valid = 1'b1;
    mode  = 2'd3;
    cycle();
    check("blink accept ready", {7'd0, o_mode_ready}, 8'd0);
    check("blink accept led",   o_led,                8'h08);
    mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      wait_step($sformatf("walk tail %0d", i));
      check($sformatf("walk tail %0d led", i),  o_led,          walk_seq[i]);
      check($sformatf("walk tail %0d busy", i), {7'd0, o_busy}, 8'd1);
      check($sformatf("walk tail %0d mode", i), {6'd0, o_mode}, 8'd1);
    end
    wait_step("blink apply");
    check("blink apply led",   o_led,                8'hFF);
    check("blink apply mode",  {6'd0, o_mode},       8'd3);
    check("blink apply ready", {7'd0, o_mode_ready}, 8'd1);
    valid = 1'b0;
    wait_step("blink off");
    check("blink off led",  o_led,          8'h00);
    wait_step("blink on");
    check("blink on led",   o_led,          8'hFF);
    check("blink on mode",  {6'd0, o_mode}, 8'd3);

    // BOUNCE accepted once ready is back; applied after BLINK finishes its pair.
    valid = 1'b1;
    mode  = 2'd2;
    cycle();
    valid = 1'b0;
    check("bounce accept ready", {7'd0, o_mode_ready}, 8'd0);
    wait_step("blink last");
    check("blink last led",  o_led,          8'h00);
    check("blink last mode", {6'd0, o_mode}, 8'd3);
    wait_step("bounce apply");
    check("bounce apply led",  o_led,          8'h01);
    check("bounce apply mode", {6'd0, o_mode}, 8'd2);
    for (int i = 0; i < 14; i++) begin
      wait_step($sformatf("bounce %0d", i));
      check($sformatf("bounce %0d led", i), o_led, bounce_seq[i]);
    end

    // Reset with BLINK pending mid-BOUNCE.
    valid = 1'b1;
    mode  = 2'd3;
    cycle();
    valid = 1'b0;
    check("pending busy", {7'd0, o_busy}, 8'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst led",   o_led,                8'h00);
    check("midrst mode",  {6'd0, o_mode},       8'd0);
    check("midrst ready", {7'd0, o_mode_ready}, 8'd1);
    check("midrst busy",  {7'd0, o_busy},       8'd0);
    check("midrst step",  {7'd0, o_step},       8'd0);
    run_vecs(12, 19);
  endtask
`else
  task automatic pwm_window(input logic [3:0] d, input int exp_on);
    int on;
    duty = d;
    on   = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_led == 8'hFF) on++;
      cycle();
    end
    check($sformatf("pwm duty %0d on-cycles", d), 8'(on), 8'(exp_on));
  endtask

  task automatic run_main();
    duty  = 4'd0;
    rst   = 1'b1;
    repeat (2) cycle();
    rst   = 1'b0;
    valid = 1'b1;
    mode  = 2'd3;
    cycle();
    valid = 1'b0;
    wait_step("pwm blink apply");
    check("pwm blink mode", {6'd0, o_mode}, 8'd3);
    pwm_window(4'd0, 0);
    wait_step("pwm off phase a");
    wait_step("pwm on phase a");
    pwm_window(4'd8, 8);
    wait_step("pwm off phase b");
    wait_step("pwm on phase b");
    pwm_window(4'd15, 15);
  endtask
`endif

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    mode  = 2'd0;
    @(negedge clk);
    run_main();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
